// File: rtl/cmd_parser.sv
// Command frame decoder: validates HEADER/ADDR/DATA/CSUM frames from the USB
// receive path, updates waveform settings and returns an ACK/NAK byte.
module cmd_parser #(
    parameter logic [7:0] HEADER    = 8'h55,
    parameter int         TIMEOUT   = 50000,
    parameter int         NUM_WAVES = 5,
    parameter logic [7:0] ACK_BYTE  = 8'h06,
    parameter logic [7:0] NAK_BYTE  = 8'h15
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] rx_data,
    input  logic       rx_valid,
    output logic [7:0] ack_data,
    output logic       ack_valid,
    input  logic       ack_ready,
    output logic [4:0] state,
    output logic [7:0] state_freq,
    output logic [7:0] state_amp,
    output logic [7:0] state_phase,
    output logic       cfg_update,
    output logic       cfg_err
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_ADDR = 3'd1,
        S_DATA = 3'd2,
        S_CSUM = 3'd3,
        S_RESP = 3'd4
    } fsm_t;

    localparam logic [15:0] TO_LAST    = 16'(TIMEOUT - 1);
    localparam logic [8:0]  WAVE_LIMIT = 9'(NUM_WAVES);

    fsm_t        fsm_r;
    logic [15:0] idle_cnt_r;
    logic [7:0]  addr_r;
    logic [7:0]  data_r;

    function automatic logic [7:0] frame_csum(input logic [7:0] a, input logic [7:0] d);
        return a ^ d;
    endfunction

    function automatic logic frame_legal(input logic [7:0] a, input logic [7:0] d);
        logic ok;
        case (a)
            8'h01:   ok = ({1'b0, d} < WAVE_LIMIT);
            8'h02:   ok = 1'b1;
            8'h03:   ok = 1'b1;
            8'h04:   ok = 1'b1;
            default: ok = 1'b0;
        endcase
        return ok;
    endfunction

    // Frame FSM, idle timeout, setting registers and response handshake.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fsm_r       <= S_IDLE;
            idle_cnt_r  <= 16'd0;
            addr_r      <= 8'h00;
            data_r      <= 8'h00;
            state       <= 5'd0;
            state_freq  <= 8'h01;
            state_amp   <= 8'h80;
            state_phase <= 8'h00;
            ack_data    <= 8'h00;
            ack_valid   <= 1'b0;
            cfg_update  <= 1'b0;
            cfg_err     <= 1'b0;
        end else begin
            cfg_update <= 1'b0;
            cfg_err    <= 1'b0;
            case (fsm_r)
                S_IDLE: begin
                    idle_cnt_r <= 16'd0;
                    if (rx_valid && (rx_data == HEADER)) begin
                        fsm_r <= S_ADDR;
                    end else begin
                        fsm_r <= S_IDLE;
                    end
                end
                S_ADDR, S_DATA, S_CSUM: begin
                    if (rx_valid) begin
                        idle_cnt_r <= 16'd0;
                        if (fsm_r == S_ADDR) begin
                            addr_r <= rx_data;
                            fsm_r  <= S_DATA;
                        end else if (fsm_r == S_DATA) begin
                            data_r <= rx_data;
                            fsm_r  <= S_CSUM;
                        end else begin
                            fsm_r     <= S_RESP;
                            ack_valid <= 1'b1;
                            if ((rx_data == frame_csum(addr_r, data_r)) && frame_legal(addr_r, data_r)) begin
                                cfg_update <= 1'b1;
                                ack_data   <= ACK_BYTE;
                                case (addr_r)
                                    8'h01:   state       <= data_r[4:0];
                                    8'h02:   state_freq  <= data_r;
                                    8'h03:   state_amp   <= data_r;
                                    8'h04:   state_phase <= data_r;
                                    default: state       <= state;
                                endcase
                            end else begin
                                cfg_err  <= 1'b1;
                                ack_data <= NAK_BYTE;
                            end
                        end
                    end else if (idle_cnt_r == TO_LAST) begin
                        // Silent abort: no response byte on timeout.
                        idle_cnt_r <= 16'd0;
                        fsm_r      <= S_IDLE;
                        cfg_err    <= 1'b1;
                    end else begin
                        idle_cnt_r <= idle_cnt_r + 16'd1;
                    end
                end
                S_RESP: begin
                    idle_cnt_r <= 16'd0;
                    if (ack_valid && ack_ready) begin
                        ack_valid <= 1'b0;
                        fsm_r     <= S_IDLE;
                    end else begin
                        fsm_r <= S_RESP;
                    end
                end
                default: begin
                    idle_cnt_r <= 16'd0;
                    ack_valid  <= 1'b0;
                    fsm_r      <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cmd_parser.sv
// Directed self-checking bench for cmd_parser (short TIMEOUT for quick runs).
module tb_cmd_parser;

    localparam int TO = 40;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic [7:0] ack_data;
    logic       ack_valid;
    logic       ack_ready;
    logic [4:0] state;
    logic [7:0] state_freq;
    logic [7:0] state_amp;
    logic [7:0] state_phase;
    logic       cfg_update;
    logic       cfg_err;

    int errors = 0;
    int checks = 0;

    cmd_parser #(.TIMEOUT(TO)) dut (
        .clk(clk), .rst_n(rst_n), .rx_data(rx_data), .rx_valid(rx_valid),
        .ack_data(ack_data), .ack_valid(ack_valid), .ack_ready(ack_ready),
        .state(state), .state_freq(state_freq), .state_amp(state_amp),
        .state_phase(state_phase), .cfg_update(cfg_update), .cfg_err(cfg_err)
    );

    always #5 clk = ~clk;

    // Called at a negedge; the byte is sampled on the next posedge, returns at the following negedge.
    task automatic send_byte(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task automatic send_frame(input logic [7:0] a, input logic [7:0] d, input logic [7:0] c);
        send_byte(8'h55);
        send_byte(a);
        send_byte(d);
        send_byte(c);
    endtask

    task automatic test_reset;
        rst_n = 1'b0; rx_valid = 1'b0; rx_data = 8'h00; ack_ready = 1'b1;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if ({state, state_freq, state_amp, state_phase} !== {5'd0, 8'h01, 8'h80, 8'h00}) begin
            $display("FAIL reset_regs: got %h/%h/%h/%h expected 00/01/80/00", state, state_freq, state_amp, state_phase);
            errors++;
        end
        checks++;
        if ({ack_valid, ack_data, cfg_update, cfg_err} !== {1'b0, 8'h00, 1'b0, 1'b0}) begin
            $display("FAIL reset_outs: got v=%b d=%h u=%b e=%b expected 0/00/0/0", ack_valid, ack_data, cfg_update, cfg_err);
            errors++;
        end
    endtask

    task automatic test_valid_write;
        send_frame(8'h02, 8'h3C, 8'h3E);
        checks++;
        if ({state_freq, cfg_update, cfg_err, ack_valid, ack_data} !== {8'h3C, 1'b1, 1'b0, 1'b1, 8'h06}) begin
            $display("FAIL valid_write: got f=%h u=%b e=%b v=%b d=%h expected 3c/1/0/1/06", state_freq, cfg_update, cfg_err, ack_valid, ack_data);
            errors++;
        end
        @(negedge clk);
        checks++;
        if ({cfg_update, ack_valid, state_freq} !== {1'b0, 1'b0, 8'h3C}) begin
            $display("FAIL valid_write_after: got u=%b v=%b f=%h expected 0/0/3c", cfg_update, ack_valid, state_freq);
            errors++;
        end
    endtask

    task automatic test_bad_checksum;
        send_frame(8'h03, 8'h40, 8'h00);
        checks++;
        if ({state_amp, cfg_update, cfg_err, ack_valid, ack_data} !== {8'h80, 1'b0, 1'b1, 1'b1, 8'h15}) begin
            $display("FAIL bad_csum: got a=%h u=%b e=%b v=%b d=%h expected 80/0/1/1/15", state_amp, cfg_update, cfg_err, ack_valid, ack_data);
            errors++;
        end
        @(negedge clk);
        checks++;
        if ({cfg_err, ack_valid} !== 2'b00) begin
            $display("FAIL bad_csum_after: got e=%b v=%b expected 0/0", cfg_err, ack_valid);
            errors++;
        end
    endtask

    task automatic test_illegal;
        logic [7:0] fa [6] = '{8'h01, 8'h09, 8'h01, 8'h01, 8'h01, 8'h00};
        logic [7:0] fd [6] = '{8'h07, 8'h11, 8'h03, 8'h04, 8'h05, 8'h00};
        logic [7:0] fc [6] = '{8'h06, 8'h18, 8'h02, 8'h05, 8'h04, 8'h00};
        logic [4:0] exp_st [6] = '{5'd0, 5'd0, 5'd3, 5'd4, 5'd4, 5'd4};
        logic       exp_ok [6] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        for (int i = 0; i < 6; i++) begin
            send_frame(fa[i], fd[i], fc[i]);
            checks++;
            if ({state, cfg_update, cfg_err, ack_valid, ack_data} !==
                {exp_st[i], exp_ok[i], !exp_ok[i], 1'b1, (exp_ok[i] ? 8'h06 : 8'h15)}) begin
                $display("FAIL illegal_%0d: got s=%0d u=%b e=%b v=%b d=%h expected s=%0d ok=%b",
                         i, state, cfg_update, cfg_err, ack_valid, ack_data, exp_st[i], exp_ok[i]);
                errors++;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_timeout;
        int early;
        send_byte(8'h55);
        send_byte(8'h04);
        early = 0;
        for (int i = 0; i < TO - 1; i++) begin
            @(negedge clk);
            if (cfg_err || ack_valid) early++;
        end
        checks++;
        if (early != 0) begin
            $display("FAIL timeout_early: got %0d early events expected 0", early);
            errors++;
        end
        @(negedge clk);
        checks++;
        if ({cfg_err, cfg_update, ack_valid} !== 3'b100) begin
            $display("FAIL timeout_fire: got e=%b u=%b v=%b expected 1/0/0", cfg_err, cfg_update, ack_valid);
            errors++;
        end
        @(negedge clk);
        checks++;
        if ({cfg_err, ack_valid} !== 2'b00) begin
            $display("FAIL timeout_pulse: got e=%b v=%b expected 0/0", cfg_err, ack_valid);
            errors++;
        end
        send_frame(8'h04, 8'h10, 8'h14);
        checks++;
        if ({state_phase, cfg_update, ack_data} !== {8'h10, 1'b1, 8'h06}) begin
            $display("FAIL timeout_recover: got p=%h u=%b d=%h expected 10/1/06", state_phase, cfg_update, ack_data);
            errors++;
        end
        @(negedge clk);
    endtask

    task automatic test_timeout_boundary;
        int errs_seen;
        send_byte(8'h55);
        send_byte(8'h04);
        errs_seen = 0;
        for (int i = 0; i < TO - 1; i++) begin
            @(negedge clk);
            if (cfg_err) errs_seen++;
        end
        send_byte(8'h20);
        if (cfg_err) errs_seen++;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (cfg_err) errs_seen++;
        end
        checks++;
        if (errs_seen != 0) begin
            $display("FAIL timeout_boundary: got %0d cfg_err pulses expected 0", errs_seen);
            errors++;
        end
        send_byte(8'h24);
        checks++;
        if ({state_phase, cfg_update, ack_valid, ack_data} !== {8'h20, 1'b1, 1'b1, 8'h06}) begin
            $display("FAIL timeout_boundary_frame: got p=%h u=%b v=%b d=%h expected 20/1/1/06", state_phase, cfg_update, ack_valid, ack_data);
            errors++;
        end
        @(negedge clk);
    endtask

    task automatic test_backpressure_reset;
        int unstable;
        ack_ready = 1'b0;
        send_frame(8'h02, 8'h77, 8'h75);
        checks++;
        if ({state_freq, ack_valid, ack_data} !== {8'h77, 1'b1, 8'h06}) begin
            $display("FAIL bp_accept: got f=%h v=%b d=%h expected 77/1/06", state_freq, ack_valid, ack_data);
            errors++;
        end
        unstable = 0;
        for (int i = 0; i < 20; i++) begin
            rx_data  = 8'h55;
            rx_valid = (i % 4 == 0);
            @(negedge clk);
            if ({ack_valid, ack_data, cfg_update, cfg_err} !== {1'b1, 8'h06, 1'b0, 1'b0}) unstable++;
        end
        rx_valid = 1'b0;
        checks++;
        if (unstable != 0) begin
            $display("FAIL bp_hold: got %0d unstable cycles expected 0", unstable);
            errors++;
        end
        ack_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (ack_valid !== 1'b0) begin
            $display("FAIL bp_release: got v=%b expected 0", ack_valid);
            errors++;
        end
        send_byte(8'h55);
        send_byte(8'h03);
        rst_n = 1'b0;
        #1;
        checks++;
        if ({state, state_freq, state_amp, state_phase, ack_valid, ack_data, cfg_update, cfg_err} !==
            {5'd0, 8'h01, 8'h80, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0}) begin
            $display("FAIL mid_reset: got s=%0d f=%h a=%h p=%h v=%b d=%h expected 0/01/80/00/0/00",
                     state, state_freq, state_amp, state_phase, ack_valid, ack_data);
            errors++;
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        send_frame(8'h03, 8'h40, 8'h43);
        checks++;
        if ({state_amp, cfg_update, ack_valid, ack_data} !== {8'h40, 1'b1, 1'b1, 8'h06}) begin
            $display("FAIL post_reset_frame: got a=%h u=%b v=%b d=%h expected 40/1/1/06", state_amp, cfg_update, ack_valid, ack_data);
            errors++;
        end
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_valid_write();
        test_bad_checksum();
        test_illegal();
        test_timeout();
        test_timeout_boundary();
        test_backpressure_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
